cam_fill_ctrl: RTL and testbench
================================

Name: cam_fill_ctrl

Overview:
- Request-side controller placed directly upstream of the tag/data CAM cache.
- Accepts tag lookups over a valid/ready handshake and drives the CAM's read/check_tag port.
- On a miss, fetches the word from backing memory, chooses a victim slot, writes tag/data/valid into the CAM, and returns the response.
- Also executes a full-cache flush by walking every CAM entry.

Parameters:
- WORDS, 8, number of CAM entries (power of two, >=2)
- BITS, 8, data word width
- TAG_SZ, 8, tag width
- ADDR_LEFT, $clog2(WORDS)-1, MSB of CAM entry index

Ports:
- clk  in  1  system clock
- rst_  in  1  reset, asynchronous, active-low
- req_valid  in  1  lookup request present
- req_ready  out  1  controller can accept request
- req_tag  in  TAG_SZ  tag to look up
- flush  in  1  flush request, sampled only in IDLE
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_data  out  BITS  returned data
- resp_hit  out  1  1=CAM hit, 0=filled from memory
- busy  out  1  state != IDLE
- mem_req  out  1  backing-memory read request
- mem_tag  out  TAG_SZ  tag/address sent to memory
- mem_ack  in  1  memory data valid (single-cycle pulse)
- mem_rdata  in  BITS  memory data
- cam_read  out  1  CAM read strobe
- cam_check_tag  out  TAG_SZ  tag to CAM matcher
- cam_found_it  in  1  CAM hit (combinational from cam_check_tag)
- cam_data  in  BITS  CAM hit data
- cam_write_  out  1  CAM write strobe, active-low
- cam_w_addr  out  ADDR_LEFT+1  CAM write index
- cam_wdata  out  BITS  CAM write data
- cam_new_tag  out  TAG_SZ  CAM write tag
- cam_new_valid  out  1  CAM write valid bit

Behaviour:
- Reset values:
  - state=IDLE; req_ready=1; resp_valid=0; resp_data=0; resp_hit=0; busy=0.
  - mem_req=0; mem_tag=0.
  - cam_read=0; cam_check_tag=0; cam_write_=1; cam_w_addr=0; cam_wdata=0; cam_new_tag=0; cam_new_valid=0.
  - Internal vld_map=0; rr_ptr=0; flush counter=0.
- req_ready=1 only in IDLE, and only when flush is low.
- States:
  - IDLE:
    - flush=1 -> FLUSH. Flush has priority over a simultaneous req_valid; the request is not accepted.
    - Else req_valid -> capture req_tag into tag_q, go LOOKUP.
  - LOOKUP (1 cycle):
    - cam_read=1, cam_check_tag=tag_q; sample cam_found_it/cam_data.
    - Hit -> resp_data=cam_data, resp_hit=1, go RESP.
    - Miss -> MEM_REQ.
  - MEM_REQ:
    - mem_req=1, mem_tag=tag_q, both held stable until mem_ack.
    - On mem_ack: capture mem_rdata, drop mem_req the next cycle, go FILL.
    - mem_ack is legal in the first MEM_REQ cycle.
  - FILL (1 cycle):
    - cam_write_=0, cam_w_addr=victim, cam_new_tag=tag_q, cam_wdata=captured data, cam_new_valid=1.
    - Set vld_map[victim]; resp_hit=0, resp_data=captured data; go RESP.
  - RESP:
    - resp_valid=1 with data held stable until resp_ready; on resp_ready -> IDLE.
    - resp_valid deasserts the cycle after the handshake.
  - FLUSH (WORDS cycles):
    - cycle k: cam_write_=0, cam_w_addr=k, cam_new_valid=0, cam_new_tag=0, cam_wdata=0.
    - After k=WORDS-1: vld_map=0, rr_ptr=0, go IDLE.
- Victim selection:
  - If vld_map is not all ones: lowest-index clear bit.
  - Else: rr_ptr. rr_ptr increments modulo WORDS after each full-cache fill and wraps WORDS-1 -> 0.
- cam_write_=1 in every state except FILL and FLUSH. Exactly one write pulse per miss.
- Latency:
  - Hit: request accepted at edge N -> resp_valid at N+2.
  - Miss: mem_req from N+2; mem_ack at M -> CAM write at M+1 -> resp_valid at M+2.
- Mid-operation reset: asynchronous return to reset values. Any pending mem_req drops immediately and no partial CAM write is issued.
- Unexpected inputs: mem_ack outside MEM_REQ is ignored; flush outside IDLE is ignored (not queued).

Decomposition:
- Package cam_pkg:
  - state enum: IDLE, LOOKUP, MEM_REQ, FILL, RESP, FLUSH.
  - CAM index type sized from WORDS.
- Sub-module victim_sel (combinational priority-encoder plus registered rr_ptr):
  - Inputs: vld_map, advance.
  - Output: victim index.

Test Plan:
- Reset, then req_tag=0x11 -> LOOKUP miss; mem_ack with mem_rdata=0xA5 after 3 cycles -> CAM write addr 0, tag 0x11, valid 1; resp_data=0xA5, resp_hit=0.
- Repeat req_tag=0x11 -> resp_valid 2 cycles after acceptance, resp_hit=1, resp_data=0xA5, mem_req never asserted.
- Fill 8 distinct tags 0x20..0x27 -> written to addrs 0..7 in order. A 9th miss (tag 0x30) goes to addr 0, a 10th to addr 1 (round-robin wrap).
- Hold resp_ready=0 for 5 cycles -> resp_valid and resp_data stable, req_ready=0; release -> IDLE next cycle.
- flush and req_valid asserted together in IDLE -> request not accepted; 8 consecutive writes addr 0..7 with valid=0; then req_tag=0x20 misses.
- Assert rst_ low during MEM_REQ -> mem_req=0 immediately, cam_write_=1, all outputs at reset values; next lookup behaves as from cold state.

Source files
------------

// File: rtl/cam_fill_ctrl_pkg.sv
// Shared types and defaults for the CAM fill controller.
//   state_e  : controller states
//   cam_idx_t: CAM entry index for the default geometry
//   cam_wr_t : one CAM write (index, tag, data, valid)
package cam_fill_ctrl_pkg;

  localparam int unsigned CAM_WORDS  = 8;
  localparam int unsigned CAM_BITS   = 8;
  localparam int unsigned CAM_TAG_SZ = 8;
  localparam int unsigned CAM_IDX_W  = $clog2(CAM_WORDS);

  typedef logic [CAM_IDX_W-1:0] cam_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_REQ,
    FILL,
    RESP,
    FLUSH
  } state_e;

  typedef struct packed {
    cam_idx_t                addr;
    logic [CAM_TAG_SZ-1:0]   tag;
    logic [CAM_BITS-1:0]     data;
    logic                    valid;
  } cam_wr_t;

endpackage

// File: rtl/cam_fill_ctrl_if.sv
// Bundle of every non-clock/reset signal of the CAM fill controller.
//   master: the controller (accepts lookups, drives memory and CAM ports)
//   slave : the surroundings (requester, backing memory, CAM)
// Groups: request (req_*, flush), response (resp_*), status (busy),
// memory (mem_*), CAM read/check (cam_read, cam_check_tag, cam_found_it,
// cam_data), CAM write (cam_write_, cam_w_addr, cam_wdata, cam_new_tag,
// cam_new_valid).
interface cam_fill_ctrl_if #(
  parameter int unsigned WORDS     = 8,
  parameter int unsigned BITS      = 8,
  parameter int unsigned TAG_SZ    = 8,
  parameter int unsigned ADDR_LEFT = $clog2(WORDS) - 1
);

  logic              req_valid;
  logic              req_ready;
  logic [TAG_SZ-1:0] req_tag;
  logic              flush;
  logic              resp_valid;
  logic              resp_ready;
  logic [BITS-1:0]   resp_data;
  logic              resp_hit;
  logic              busy;
  logic              mem_req;
  logic [TAG_SZ-1:0] mem_tag;
  logic              mem_ack;
  logic [BITS-1:0]   mem_rdata;
  logic              cam_read;
  logic [TAG_SZ-1:0] cam_check_tag;
  logic              cam_found_it;
  logic [BITS-1:0]   cam_data;
  logic              cam_write_;
  logic [ADDR_LEFT:0] cam_w_addr;
  logic [BITS-1:0]   cam_wdata;
  logic [TAG_SZ-1:0] cam_new_tag;
  logic              cam_new_valid;

  modport master (
    input  req_valid, req_tag, flush, resp_ready, mem_ack, mem_rdata,
           cam_found_it, cam_data,
    output req_ready, resp_valid, resp_data, resp_hit, busy, mem_req, mem_tag,
           cam_read, cam_check_tag, cam_write_, cam_w_addr, cam_wdata,
           cam_new_tag, cam_new_valid
  );

  modport slave (
    output req_valid, req_tag, flush, resp_ready, mem_ack, mem_rdata,
           cam_found_it, cam_data,
    input  req_ready, resp_valid, resp_data, resp_hit, busy, mem_req, mem_tag,
           cam_read, cam_check_tag, cam_write_, cam_w_addr, cam_wdata,
           cam_new_tag, cam_new_valid
  );

endinterface

// File: rtl/cam_fill_ctrl_victim_sel.sv
// Victim slot chooser for CAM fills.
//   clk, rst_   : clock, async active-low reset
//   vld_map_i   : occupancy map of the CAM entries
//   advance_i   : a fill into a full cache happened; step the round-robin pointer
//   clr_i       : return the round-robin pointer to entry 0
//   victim_c_o  : lowest free entry, or the round-robin entry when full
module cam_fill_ctrl_victim_sel #(
  parameter int unsigned WORDS = 8
) (
  input  logic                       clk,
  input  logic                       rst_,
  input  logic [WORDS-1:0]           vld_map_i,
  input  logic                       advance_i,
  input  logic                       clr_i,
  output logic [$clog2(WORDS)-1:0]   victim_c_o
);

  localparam int unsigned IDX_W = $clog2(WORDS);

  logic [IDX_W-1:0] rr_q;
  logic [IDX_W-1:0] free_idx;
  logic             full;

  // Priority encoder: scanning downward leaves the lowest clear bit last.
  always_comb begin
    free_idx = '0;
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (!vld_map_i[IDX_W'(i)]) free_idx = IDX_W'(i);
    end
  end

  assign full       = &vld_map_i;
  assign victim_c_o = full ? rr_q : free_idx;

  // Round-robin pointer; WORDS is a power of two so the add wraps naturally.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)          rr_q <= '0;
    else if (clr_i)     rr_q <= '0;
    else if (advance_i) rr_q <= IDX_W'(rr_q + 1'b1);
  end

endmodule

// File: rtl/cam_fill_ctrl.sv
// Request-side controller in front of the tag/data CAM: looks tags up,
// fills misses from backing memory into a victim slot, returns responses,
// and walks every entry invalid on a flush.
//   clk, rst_ : clock, async active-low reset
//   bus       : cam_fill_ctrl_if.master (request, response, busy, memory,
//               CAM read/check and CAM write groups)
module cam_fill_ctrl
  import cam_fill_ctrl_pkg::*;
#(
  parameter int unsigned WORDS     = CAM_WORDS,
  parameter int unsigned BITS      = CAM_BITS,
  parameter int unsigned TAG_SZ    = CAM_TAG_SZ,
  parameter int unsigned ADDR_LEFT = $clog2(WORDS) - 1
) (
  input  logic             clk,
  input  logic             rst_,
  cam_fill_ctrl_if.master  bus
);

  localparam int unsigned IDX_W = ADDR_LEFT + 1;

  state_e             state_q, state_d;
  logic [TAG_SZ-1:0]  tag_q, tag_d;
  logic [WORDS-1:0]   vld_map_q, vld_map_d;
  logic [IDX_W-1:0]   fcnt_q, fcnt_d;
  logic [IDX_W-1:0]   victim;
  logic               advance;
  logic               rr_clr;

  logic               resp_valid_q, resp_valid_d;
  logic [BITS-1:0]    resp_data_q, resp_data_d;
  logic               resp_hit_q, resp_hit_d;
  logic               busy_q, busy_d;
  logic               mem_req_q, mem_req_d;
  logic [TAG_SZ-1:0]  mem_tag_q, mem_tag_d;
  logic               cam_read_q, cam_read_d;
  logic [TAG_SZ-1:0]  cam_check_tag_q, cam_check_tag_d;
  logic               cam_write_n_q, cam_write_n_d;
  logic [IDX_W-1:0]   cam_w_addr_q, cam_w_addr_d;
  logic [BITS-1:0]    cam_wdata_q, cam_wdata_d;
  logic [TAG_SZ-1:0]  cam_new_tag_q, cam_new_tag_d;
  logic               cam_new_valid_q, cam_new_valid_d;

  cam_fill_ctrl_victim_sel #(.WORDS(WORDS)) u_victim_sel (
    .clk        (clk),
    .rst_       (rst_),
    .vld_map_i  (vld_map_q),
    .advance_i  (advance),
    .clr_i      (rr_clr),
    .victim_c_o (victim)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state; every output register is loaded with the value it must show
  // in the state being entered, so outputs line up with the state.
  always_comb begin
    state_d         = state_q;
    tag_d           = tag_q;
    vld_map_d       = vld_map_q;
    fcnt_d          = fcnt_q;
    advance         = 1'b0;
    rr_clr          = 1'b0;
    resp_valid_d    = resp_valid_q;
    resp_data_d     = resp_data_q;
    resp_hit_d      = resp_hit_q;
    mem_req_d       = 1'b0;
    mem_tag_d       = mem_tag_q;
    cam_read_d      = 1'b0;
    cam_check_tag_d = cam_check_tag_q;
    cam_write_n_d   = 1'b1;
    cam_w_addr_d    = cam_w_addr_q;
    cam_wdata_d     = cam_wdata_q;
    cam_new_tag_d   = cam_new_tag_q;
    cam_new_valid_d = cam_new_valid_q;

    case (state_q)
      IDLE: begin
        // Flush wins over a simultaneous request; first walk write is entry 0.
        if (bus.flush) begin
          state_d         = FLUSH;
          fcnt_d          = '0;
          cam_write_n_d   = 1'b0;
          cam_w_addr_d    = '0;
          cam_wdata_d     = '0;
          cam_new_tag_d   = '0;
          cam_new_valid_d = 1'b0;
        end else if (bus.req_valid) begin
          state_d         = LOOKUP;
          tag_d           = bus.req_tag;
          cam_read_d      = 1'b1;
          cam_check_tag_d = bus.req_tag;
        end
      end
      LOOKUP: begin
        if (bus.cam_found_it) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_data_d  = bus.cam_data;
          resp_hit_d   = 1'b1;
        end else begin
          state_d   = MEM_REQ;
          mem_req_d = 1'b1;
          mem_tag_d = tag_q;
        end
      end
      MEM_REQ: begin
        if (bus.mem_ack) begin
          state_d          = FILL;
          cam_write_n_d    = 1'b0;
          cam_w_addr_d     = victim;
          cam_wdata_d      = bus.mem_rdata;
          cam_new_tag_d    = tag_q;
          cam_new_valid_d  = 1'b1;
          vld_map_d[victim] = 1'b1;
          advance          = &vld_map_q;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      FILL: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_data_d  = cam_wdata_q;
        resp_hit_d   = 1'b0;
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      FLUSH: begin
        if (fcnt_q == IDX_W'(WORDS - 1)) begin
          state_d   = IDLE;
          vld_map_d = '0;
          rr_clr    = 1'b1;
        end else begin
          fcnt_d        = IDX_W'(fcnt_q + 1'b1);
          cam_write_n_d = 1'b0;
          cam_w_addr_d  = IDX_W'(fcnt_q + 1'b1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      tag_q           <= '0;
      vld_map_q       <= '0;
      fcnt_q          <= '0;
      resp_valid_q    <= 1'b0;
      resp_data_q     <= '0;
      resp_hit_q      <= 1'b0;
      busy_q          <= 1'b0;
      mem_req_q       <= 1'b0;
      mem_tag_q       <= '0;
      cam_read_q      <= 1'b0;
      cam_check_tag_q <= '0;
      cam_write_n_q   <= 1'b1;
      cam_w_addr_q    <= '0;
      cam_wdata_q     <= '0;
      cam_new_tag_q   <= '0;
      cam_new_valid_q <= 1'b0;
    end else begin
      tag_q           <= tag_d;
      vld_map_q       <= vld_map_d;
      fcnt_q          <= fcnt_d;
      resp_valid_q    <= resp_valid_d;
      resp_data_q     <= resp_data_d;
      resp_hit_q      <= resp_hit_d;
      busy_q          <= busy_d;
      mem_req_q       <= mem_req_d;
      mem_tag_q       <= mem_tag_d;
      cam_read_q      <= cam_read_d;
      cam_check_tag_q <= cam_check_tag_d;
      cam_write_n_q   <= cam_write_n_d;
      cam_w_addr_q    <= cam_w_addr_d;
      cam_wdata_q     <= cam_wdata_d;
      cam_new_tag_q   <= cam_new_tag_d;
      cam_new_valid_q <= cam_new_valid_d;
    end
  end

  // Ready must drop in the same cycle flush is raised, hence the live gate.
  assign bus.req_ready     = (state_q == IDLE) && !bus.flush;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_data     = resp_data_q;
  assign bus.resp_hit      = resp_hit_q;
  assign bus.busy          = busy_q;
  assign bus.mem_req       = mem_req_q;
  assign bus.mem_tag       = mem_tag_q;
  assign bus.cam_read      = cam_read_q;
  assign bus.cam_check_tag = cam_check_tag_q;
  assign bus.cam_write_    = cam_write_n_q;
  assign bus.cam_w_addr    = cam_w_addr_q;
  assign bus.cam_wdata     = cam_wdata_q;
  assign bus.cam_new_tag   = cam_new_tag_q;
  assign bus.cam_new_valid = cam_new_valid_q;

endmodule

// File: tb/tb_cam_fill_ctrl.sv
// Self-checking bench for cam_fill_ctrl: emulates the CAM and backing
// memory, keeps a transaction-level cache model, and checks writes,
// latencies, response contents and reset behaviour.
module tb_cam_fill_ctrl;
  import cam_fill_ctrl_pkg::*;

  localparam int unsigned WORDS = 8;
  localparam int unsigned BITS  = 8;
  localparam int unsigned TAGW  = 8;
  localparam int unsigned IDX_W = 3;

  logic clk = 1'b0;
  logic rst_;
  always #5 clk = ~clk;

  cam_fill_ctrl_if #(.WORDS(WORDS), .BITS(BITS), .TAG_SZ(TAGW)) bus ();

  cam_fill_ctrl #(.WORDS(WORDS), .BITS(BITS), .TAG_SZ(TAGW)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    else n_pass++;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- emulated CAM (updated only by DUT writes) ----------------
  logic            cam_clr;
  logic            c_valid [WORDS];
  logic [TAGW-1:0] c_tag   [WORDS];
  logic [BITS-1:0] c_data  [WORDS];

  always @(posedge clk) begin
    if (cam_clr) begin
      for (int i = 0; i < WORDS; i++) c_valid[i] <= 1'b0;
    end else if (rst_ && !bus.cam_write_) begin
      c_valid[bus.cam_w_addr] <= bus.cam_new_valid;
      c_tag[bus.cam_w_addr]   <= bus.cam_new_tag;
      c_data[bus.cam_w_addr]  <= bus.cam_wdata;
    end
  end

  always_comb begin
    bus.cam_found_it = 1'b0;
    bus.cam_data     = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (c_valid[i] && c_tag[i] == bus.cam_check_tag) begin
        bus.cam_found_it = 1'b1;
        bus.cam_data     = c_data[i];
      end
    end
  end

  // ---------------- cache model ----------------
  logic            m_cv [WORDS];
  logic [TAGW-1:0] m_ct [WORDS];
  logic [BITS-1:0] m_cd [WORDS];
  logic [WORDS-1:0] m_map;
  int              m_rr;
  cam_wr_t         exp_wr[$];
  logic            mem_allowed;

  task automatic model_lookup(input logic [TAGW-1:0] tag, input logic [BITS-1:0] mdata,
                              output logic hit, output logic [BITS-1:0] data);
    int v;
    cam_wr_t w;
    hit  = 1'b0;
    data = mdata;
    for (int i = 0; i < WORDS; i++)
      if (m_cv[i] && m_ct[i] == tag) begin hit = 1'b1; data = m_cd[i]; end
    if (!hit) begin
      v = -1;
      for (int i = WORDS - 1; i >= 0; i--) if (!m_map[i]) v = i;
      if (v < 0) begin v = m_rr; m_rr = (m_rr + 1) % WORDS; end
      m_map[v] = 1'b1;
      m_cv[v]  = 1'b1;
      m_ct[v]  = tag;
      m_cd[v]  = mdata;
      w.addr = IDX_W'(v); w.tag = tag; w.data = mdata; w.valid = 1'b1;
      exp_wr.push_back(w);
    end
  endtask

  task automatic model_flush();
    cam_wr_t w;
    for (int k = 0; k < WORDS; k++) begin
      w.addr = IDX_W'(k); w.tag = '0; w.data = '0; w.valid = 1'b0;
      exp_wr.push_back(w);
      m_cv[k] = 1'b0;
    end
    m_map = '0;
    m_rr  = 0;
  endtask

  // ---------------- per-cycle compare process ----------------
  cam_wr_t         last_wr;
  logic            prev_v;
  logic [BITS-1:0] prev_d;
  logic            hs_q;

  always @(posedge clk) hs_q <= bus.resp_valid && bus.resp_ready;

  always @(negedge clk) begin
    cam_wr_t w;
    if (!rst_) begin
      prev_v <= 1'b0;
    end else begin
      if (!bus.cam_write_) begin
        if (exp_wr.size() == 0) begin
          chk("cam_write_unexpected", 32'(bus.cam_write_), 32'd1);
        end else begin
          w = exp_wr.pop_front();
          chk("wr_addr",  32'(bus.cam_w_addr),    32'(w.addr));
          chk("wr_tag",   32'(bus.cam_new_tag),   32'(w.tag));
          chk("wr_data",  32'(bus.cam_wdata),     32'(w.data));
          chk("wr_valid", 32'(bus.cam_new_valid), 32'(w.valid));
          last_wr <= w;
        end
      end
      if (!mem_allowed) chk("mem_req_unexpected", 32'(bus.mem_req), 32'd0);
      if (bus.busy)     chk("req_ready_while_busy", 32'(bus.req_ready), 32'd0);
      if (prev_v && !hs_q) begin
        chk("resp_valid_hold", 32'(bus.resp_valid), 32'd1);
        chk("resp_data_hold",  32'(bus.resp_data),  32'(prev_d));
      end
      prev_v <= bus.resp_valid;
      prev_d <= bus.resp_data;
    end
  end

  // ---------------- directed transactions ----------------
  task automatic do_lookup(input logic [TAGW-1:0] tag, input logic [BITS-1:0] mdata,
                           input int ack_dly, input int hold,
                           output logic hit_o, output logic [BITS-1:0] data_o);
    logic e_hit;
    logic [BITS-1:0] e_data;
    int n_edge, start_edge, t;
    model_lookup(tag, mdata, e_hit, e_data);
    mem_allowed = !e_hit;
    @(negedge clk);
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_tag   = tag;
    n_edge = cyc + 1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("cam_read", 32'(bus.cam_read), 32'd1);
    chk("cam_check_tag", 32'(bus.cam_check_tag), 32'(tag));
    start_edge = n_edge;
    if (!e_hit) begin
      t = 0;
      while (!bus.mem_req && t < 20) begin @(negedge clk); t++; end
      chk("mem_req_seen", 32'(bus.mem_req), 32'd1);
      chk("mem_req_latency", 32'(cyc + 1 - n_edge), 32'd2);
      chk("mem_tag", 32'(bus.mem_tag), 32'(tag));
      repeat (ack_dly) @(negedge clk);
      chk("mem_req_held", 32'(bus.mem_req), 32'd1);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = mdata;
      start_edge = cyc + 1;
      @(posedge clk);
      #1 bus.mem_ack = 1'b0;
      bus.mem_rdata = '0;
      @(negedge clk);
      chk("mem_req_drop", 32'(bus.mem_req), 32'd0);
    end
    t = 0;
    while (!bus.resp_valid && t < 20) begin @(negedge clk); t++; end
    chk("resp_valid_seen", 32'(bus.resp_valid), 32'd1);
    chk("resp_latency", 32'(cyc + 1 - start_edge), 32'd2);
    chk("resp_hit", 32'(bus.resp_hit), 32'(e_hit));
    chk("resp_data", 32'(bus.resp_data), 32'(e_data));
    chk("writes_done", 32'(exp_wr.size()), 32'd0);
    hit_o  = bus.resp_hit;
    data_o = bus.resp_data;
    repeat (hold) @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    @(negedge clk);
    chk("resp_valid_drop", 32'(bus.resp_valid), 32'd0);
    chk("idle_after_resp", 32'(bus.busy), 32'd0);
    mem_allowed = 1'b0;
  endtask

  task automatic do_flush(input logic with_req);
    int t, busy_cnt, reads;
    model_flush();
    @(negedge clk);
    bus.flush = 1'b1;
    if (with_req) begin bus.req_valid = 1'b1; bus.req_tag = 8'h55; end
    #1 chk("req_ready_on_flush", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1 bus.flush = 1'b0;
    bus.req_valid = 1'b0;
    busy_cnt = 0; reads = 0; t = 0;
    @(negedge clk);
    while (bus.busy && t < 50) begin
      busy_cnt++;
      if (bus.cam_read) reads++;
      @(negedge clk);
      t++;
    end
    chk("flush_cycles", 32'(busy_cnt), 32'(WORDS));
    chk("flush_no_lookup", 32'(reads), 32'd0);
    chk("flush_writes_done", 32'(exp_wr.size()), 32'd0);
    chk("flush_ready_after", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic h;
    logic [BITS-1:0] d;
    int t;
    rst_ = 1'b0; cam_clr = 1'b1; mem_allowed = 1'b0;
    bus.req_valid = 1'b0; bus.req_tag = '0; bus.flush = 1'b0;
    bus.resp_ready = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    for (int i = 0; i < WORDS; i++) begin m_cv[i] = 1'b0; m_ct[i] = '0; m_cd[i] = '0; end
    m_map = '0; m_rr = 0;
    repeat (3) @(negedge clk);

    // reset values
    chk("rst_req_ready",  32'(bus.req_ready),  32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_data",  32'(bus.resp_data),  32'd0);
    chk("rst_busy",       32'(bus.busy),       32'd0);
    chk("rst_mem_req",    32'(bus.mem_req),    32'd0);
    chk("rst_cam_write_", 32'(bus.cam_write_), 32'd1);
    chk("rst_cam_read",   32'(bus.cam_read),   32'd0);
    chk("rst_cam_w_addr", 32'(bus.cam_w_addr), 32'd0);
    cam_clr = 1'b0;
    rst_    = 1'b1;
    repeat (2) @(negedge clk);

    // cold miss then hit on 0x11
    do_lookup(8'h11, 8'hA5, 3, 0, h, d);
    chk("lit_miss_hit", 32'(h), 32'd0);
    chk("lit_miss_data", 32'(d), 32'hA5);
    chk("lit_miss_addr", 32'(last_wr.addr), 32'd0);
    chk("lit_miss_tag", 32'(last_wr.tag), 32'h11);
    do_lookup(8'h11, 8'h00, 0, 0, h, d);
    chk("lit_hit_hit", 32'(h), 32'd1);
    chk("lit_hit_data", 32'(d), 32'hA5);

    // stray mem_ack while idle must do nothing
    @(negedge clk);
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'hEE;
    @(posedge clk);
    #1 bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_idle", 32'(bus.busy), 32'd0);

    // clean slate, fill 0x20..0x27 into 0..7, then round-robin wrap
    do_flush(1'b0);
    for (int i = 0; i < 8; i++) begin
      do_lookup(8'(8'h20 + i), 8'(8'h20 + i) ^ 8'h5A, i % 3, 0, h, d);
      chk("fill_addr", 32'(last_wr.addr), 32'(i));
    end
    do_lookup(8'h30, 8'h6A, 1, 0, h, d);
    chk("lit_rr_addr0", 32'(last_wr.addr), 32'd0);
    do_lookup(8'h31, 8'h6B, 0, 0, h, d);
    chk("lit_rr_addr1", 32'(last_wr.addr), 32'd1);

    // hit on 0x22 (entry 2) with the response held for 5 cycles
    do_lookup(8'h22, 8'h00, 0, 5, h, d);
    chk("lit_hold_hit", 32'(h), 32'd1);
    chk("lit_hold_data", 32'(d), 32'h78);

    // flush beats a simultaneous request; 0x20 then misses into entry 0
    do_flush(1'b1);
    do_lookup(8'h20, 8'h3C, 1, 0, h, d);
    chk("lit_post_flush_hit", 32'(h), 32'd0);
    chk("lit_post_flush_addr", 32'(last_wr.addr), 32'd0);

    // reset in MEM_REQ
    mem_allowed = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_tag = 8'h40;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    t = 0;
    @(negedge clk);
    while (!bus.mem_req && t < 20) begin @(negedge clk); t++; end
    chk("pre_rst_mem_req", 32'(bus.mem_req), 32'd1);
    #2 rst_ = 1'b0;
    #1;
    mem_allowed = 1'b0;
    chk("mid_rst_mem_req",       32'(bus.mem_req),       32'd0);
    chk("mid_rst_mem_tag",       32'(bus.mem_tag),       32'd0);
    chk("mid_rst_cam_write_",    32'(bus.cam_write_),    32'd1);
    chk("mid_rst_req_ready",     32'(bus.req_ready),     32'd1);
    chk("mid_rst_busy",          32'(bus.busy),          32'd0);
    chk("mid_rst_resp_valid",    32'(bus.resp_valid),    32'd0);
    chk("mid_rst_resp_hit",      32'(bus.resp_hit),      32'd0);
    chk("mid_rst_cam_read",      32'(bus.cam_read),      32'd0);
    chk("mid_rst_cam_check_tag", 32'(bus.cam_check_tag), 32'd0);
    chk("mid_rst_cam_w_addr",    32'(bus.cam_w_addr),    32'd0);
    chk("mid_rst_cam_new_valid", 32'(bus.cam_new_valid), 32'd0);
    @(negedge clk);
    rst_ = 1'b1;
    m_map = '0;
    m_rr  = 0;
    repeat (3) @(negedge clk);
    do_lookup(8'h41, 8'h99, 2, 0, h, d);
    chk("lit_cold_hit", 32'(h), 32'd0);
    chk("lit_cold_addr", 32'(last_wr.addr), 32'd0);
    chk("lit_cold_data", 32'(d), 32'h99);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
